// File: rtl/circle_motion_ctrl_if.sv
// Sprite position controller bus: frame/button inputs toward the controller
// and committed circle position toward the renderer.
interface circle_motion_ctrl_if;
    logic       frame_start;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_center;
    logic [9:0] red_circle_x;
    logic [8:0] red_circle_y;
    logic       pos_valid;
    logic       moving;

    modport master (
        output frame_start, btn_up, btn_down, btn_left, btn_right, btn_center,
        input  red_circle_x, red_circle_y, pos_valid, moving
    );

    modport slave (
        input  frame_start, btn_up, btn_down, btn_left, btn_right, btn_center,
        output red_circle_x, red_circle_y, pos_valid, moving
    );
endinterface

// File: rtl/circle_motion_ctrl.sv
// Frame-synchronous red circle position controller with edge clamping.
// Optional hold-time acceleration enabled by defining MOTION_ACCEL_EN.
module circle_motion_ctrl #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int RADIUS       = 8,
    parameter int STEP         = 2,
    parameter int STEP_MAX     = 6,
    parameter int ACCEL_FRAMES = 16,
    parameter int START_X      = 320,
    parameter int START_Y      = 240
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    circle_motion_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    localparam logic signed [11:0] X_MIN = 12'(RADIUS);
    localparam logic signed [11:0] X_MAX = 12'(H_RES - 1 - RADIUS);
    localparam logic signed [11:0] Y_MIN = 12'(RADIUS);
    localparam logic signed [11:0] Y_MAX = 12'(V_RES - 1 - RADIUS);

    state_e     state_q, state_d;
    // Latched buttons: {center, up, down, left, right}
    logic [4:0] btn_q, btn_d;
    logic [9:0] sh_x_q, sh_x_d;
    logic [8:0] sh_y_q, sh_y_d;
    logic       sh_moving_q, sh_moving_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       pos_valid_q, pos_valid_d;
    logic       moving_q, moving_d;

    logic signed [11:0] step_w;
    logic signed [11:0] dx, dy;
    logic signed [11:0] x_sum, y_sum;
    logic signed [11:0] x_clamp, y_clamp;
    logic               dir_nz;

`ifdef MOTION_ACCEL_EN
    logic [7:0]  hold_q, hold_d;
    logic [11:0] hold_div;
    logic [11:0] step_raw;

    // Step grows with the pre-increment hold count, capped at STEP_MAX.
    always_comb begin
        hold_div = {4'b0000, hold_q} / 12'(ACCEL_FRAMES);
        step_raw = 12'(STEP) + hold_div;
        step_w   = (step_raw > 12'(STEP_MAX)) ? 12'(STEP_MAX) : step_raw;
    end
`else
    assign step_w = 12'(STEP);
`endif

    always_comb begin
        dx = '0;
        dy = '0;
        if (btn_q[0] && !btn_q[1]) dx = step_w;
        if (btn_q[1] && !btn_q[0]) dx = -step_w;
        if (btn_q[2] && !btn_q[3]) dy = step_w;
        if (btn_q[3] && !btn_q[2]) dy = -step_w;
        dir_nz = (dx != '0) || (dy != '0);

        x_sum = $signed({2'b00, x_q}) + dx;
        y_sum = $signed({3'b000, y_q}) + dy;

        x_clamp = x_sum;
        if (x_sum < X_MIN) x_clamp = X_MIN;
        if (x_sum > X_MAX) x_clamp = X_MAX;
        y_clamp = y_sum;
        if (y_sum < Y_MIN) y_clamp = Y_MIN;
        if (y_sum > Y_MAX) y_clamp = Y_MAX;
    end

    always_comb begin
        state_d     = state_q;
        btn_d       = btn_q;
        sh_x_d      = sh_x_q;
        sh_y_d      = sh_y_q;
        sh_moving_d = sh_moving_q;
        x_d         = x_q;
        y_d         = y_q;
        pos_valid_d = 1'b0;
        moving_d    = moving_q;
`ifdef MOTION_ACCEL_EN
        hold_d      = hold_q;
`endif

        unique case (state_q)
            S_WAIT: begin
                if (bus.frame_start) begin
                    btn_d   = {bus.btn_center, bus.btn_up, bus.btn_down,
                               bus.btn_left, bus.btn_right};
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (btn_q[4]) begin
                    sh_x_d      = 10'(START_X);
                    sh_y_d      = 9'(START_Y);
                    sh_moving_d = 1'b0;
`ifdef MOTION_ACCEL_EN
                    hold_d      = '0;
`endif
                end else begin
                    sh_x_d      = x_clamp[9:0];
                    sh_y_d      = y_clamp[8:0];
                    sh_moving_d = dir_nz;
`ifdef MOTION_ACCEL_EN
                    if (!dir_nz)
                        hold_d = '0;
                    else if (hold_q != '1)
                        hold_d = hold_q + 8'd1;
`endif
                end
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                x_d         = sh_x_q;
                y_d         = sh_y_q;
                pos_valid_d = 1'b1;
                moving_d    = sh_moving_q;
                state_d     = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_WAIT;
            btn_q       <= '0;
            sh_x_q      <= 10'(START_X);
            sh_y_q      <= 9'(START_Y);
            sh_moving_q <= 1'b0;
            x_q         <= 10'(START_X);
            y_q         <= 9'(START_Y);
            pos_valid_q <= 1'b0;
            moving_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_d;
            sh_x_q      <= sh_x_d;
            sh_y_q      <= sh_y_d;
            sh_moving_q <= sh_moving_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pos_valid_q <= pos_valid_d;
            moving_q    <= moving_d;
        end
    end

`ifdef MOTION_ACCEL_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) hold_q <= '0;
        else        hold_q <= hold_d;
    end
`endif

    assign bus.red_circle_x = x_q;
    assign bus.red_circle_y = y_q;
    assign bus.pos_valid    = pos_valid_q;
    assign bus.moving       = moving_q;

endmodule

// File: tb/tb_circle_motion_ctrl.sv
// Directed testbench for circle_motion_ctrl; expected values hand-computed.
// Define MOTION_ACCEL_EN to also exercise the acceleration profile.
module tb_circle_motion_ctrl;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;

    circle_motion_ctrl_if bus ();

    circle_motion_ctrl #(
        .H_RES(640), .V_RES(480), .RADIUS(8), .STEP(2), .STEP_MAX(6),
        .ACCEL_FRAMES(16), .START_X(320), .START_Y(240)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Buttons packed as {center, up, down, left, right}.
    task automatic set_btns(input logic [4:0] b);
        bus.btn_center = b[4];
        bus.btn_up     = b[3];
        bus.btn_down   = b[2];
        bus.btn_left   = b[1];
        bus.btn_right  = b[0];
    endtask

    // Pulse frame_start with buttons held; returns just after the commit edge.
    task automatic do_frame(input logic [4:0] b);
        @(negedge CLK);
        set_btns(b);
        bus.frame_start = 1'b1;
        @(negedge CLK);
        bus.frame_start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        bus.frame_start = 1'b0;
        set_btns(5'b00000);
        repeat (3) @(negedge CLK);
        checks++; if (bus.red_circle_x !== 10'd320) begin errors++; $display("FAIL rst_x got %0d want 320", bus.red_circle_x); end
        checks++; if (bus.red_circle_y !== 9'd240) begin errors++; $display("FAIL rst_y got %0d want 240", bus.red_circle_y); end
        checks++; if (bus.pos_valid !== 1'b0) begin errors++; $display("FAIL rst_pv got %b want 0", bus.pos_valid); end
        checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL rst_mov got %b want 0", bus.moving); end
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        for (int f = 0; f < 3; f++) begin
            @(negedge CLK);
            bus.frame_start = 1'b1;
            @(negedge CLK);
            bus.frame_start = 1'b0;
            checks++; if (bus.pos_valid !== 1'b0) begin errors++; $display("FAIL idle_pv_n0 f%0d got %b want 0", f, bus.pos_valid); end
            @(negedge CLK);
            checks++; if (bus.pos_valid !== 1'b0) begin errors++; $display("FAIL idle_pv_n1 f%0d got %b want 0", f, bus.pos_valid); end
            @(negedge CLK);
            checks++; if (bus.pos_valid !== 1'b1) begin errors++; $display("FAIL idle_pv_n2 f%0d got %b want 1", f, bus.pos_valid); end
            checks++; if (bus.red_circle_x !== 10'd320 || bus.red_circle_y !== 9'd240) begin errors++; $display("FAIL idle_pos f%0d got (%0d,%0d) want (320,240)", f, bus.red_circle_x, bus.red_circle_y); end
            checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL idle_mov f%0d got %b want 0", f, bus.moving); end
            @(negedge CLK);
            checks++; if (bus.pos_valid !== 1'b0) begin errors++; $display("FAIL idle_pv_n3 f%0d got %b want 0", f, bus.pos_valid); end
        end
    endtask

    task automatic test_move_right;
        int exp_x;
        exp_x = 320;
        for (int f = 0; f < 5; f++) begin
            do_frame(5'b00001);
            exp_x += 2;
            checks++; if (bus.red_circle_x !== 10'(exp_x)) begin errors++; $display("FAIL right_x f%0d got %0d want %0d", f, bus.red_circle_x, exp_x); end
            checks++; if (bus.red_circle_y !== 9'd240) begin errors++; $display("FAIL right_y f%0d got %0d want 240", f, bus.red_circle_y); end
            checks++; if (bus.moving !== 1'b1) begin errors++; $display("FAIL right_mov f%0d got %b want 1", f, bus.moving); end
        end
    endtask

    task automatic test_clamp;
        // Drive to the left edge, idle once to drop any hold count, then step off.
        repeat (200) do_frame(5'b00010);
        checks++; if (bus.red_circle_x !== 10'd8) begin errors++; $display("FAIL clamp_xmin got %0d want 8", bus.red_circle_x); end
        do_frame(5'b00000);
        checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL idle_mov got %b want 0", bus.moving); end
        do_frame(5'b00001);
        checks++; if (bus.red_circle_x !== 10'd10) begin errors++; $display("FAIL x_from8 got %0d want 10", bus.red_circle_x); end
        do_frame(5'b00010);
        checks++; if (bus.red_circle_x !== 10'd8) begin errors++; $display("FAIL left_1 got %0d want 8", bus.red_circle_x); end
        do_frame(5'b00010);
        checks++; if (bus.red_circle_x !== 10'd8) begin errors++; $display("FAIL left_2 got %0d want 8", bus.red_circle_x); end
        repeat (150) do_frame(5'b00100);
        checks++; if (bus.red_circle_y !== 9'd471) begin errors++; $display("FAIL clamp_ymax got %0d want 471", bus.red_circle_y); end
        do_frame(5'b00000);
        do_frame(5'b01000);
        checks++; if (bus.red_circle_y !== 9'd469) begin errors++; $display("FAIL up_from471 got %0d want 469", bus.red_circle_y); end
        do_frame(5'b00100);
        checks++; if (bus.red_circle_y !== 9'd471) begin errors++; $display("FAIL down_1 got %0d want 471", bus.red_circle_y); end
        do_frame(5'b00100);
        checks++; if (bus.red_circle_y !== 9'd471) begin errors++; $display("FAIL down_2 got %0d want 471", bus.red_circle_y); end
    endtask

    task automatic test_opposite_center;
        // Position is (8, 471) on entry.
        do_frame(5'b01011);
        checks++; if (bus.red_circle_x !== 10'd8) begin errors++; $display("FAIL opp_x got %0d want 8", bus.red_circle_x); end
        checks++; if (bus.red_circle_y !== 9'd469) begin errors++; $display("FAIL opp_y got %0d want 469", bus.red_circle_y); end
        checks++; if (bus.moving !== 1'b1) begin errors++; $display("FAIL opp_mov got %b want 1", bus.moving); end
        do_frame(5'b11000);
        checks++; if (bus.red_circle_x !== 10'd320 || bus.red_circle_y !== 9'd240) begin errors++; $display("FAIL center got (%0d,%0d) want (320,240)", bus.red_circle_x, bus.red_circle_y); end
        checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL center_mov got %b want 0", bus.moving); end
        do_frame(5'b00011);
        checks++; if (bus.red_circle_x !== 10'd320 || bus.moving !== 1'b0) begin errors++; $display("FAIL lr_only got x=%0d mov=%b want x=320 mov=0", bus.red_circle_x, bus.moving); end
    endtask

    task automatic test_reset_mid_calc;
        int pv_seen;
        do_frame(5'b00001);
        checks++; if (bus.red_circle_x !== 10'd322) begin errors++; $display("FAIL pre_rst_x got %0d want 322", bus.red_circle_x); end
        @(negedge CLK);
        set_btns(5'b00001);
        bus.frame_start = 1'b1;
        @(negedge CLK);
        bus.frame_start = 1'b0;
        RST_N = 1'b0;
        #1;
        checks++; if (bus.red_circle_x !== 10'd320 || bus.red_circle_y !== 9'd240) begin errors++; $display("FAIL midrst_pos got (%0d,%0d) want (320,240)", bus.red_circle_x, bus.red_circle_y); end
        pv_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            if (bus.pos_valid === 1'b1) pv_seen++;
        end
        RST_N = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (bus.pos_valid === 1'b1) pv_seen++;
        end
        checks++; if (pv_seen != 0) begin errors++; $display("FAIL midrst_pv got %0d pulses want 0", pv_seen); end
        checks++; if (bus.red_circle_x !== 10'd320) begin errors++; $display("FAIL postrst_x got %0d want 320", bus.red_circle_x); end
    endtask

    task automatic test_back_to_back_pulse;
        int pv_seen;
        pv_seen = 0;
        @(negedge CLK);
        set_btns(5'b00001);
        bus.frame_start = 1'b1;
        @(negedge CLK);
        bus.frame_start = 1'b1;
        @(negedge CLK);
        bus.frame_start = 1'b0;
        if (bus.pos_valid === 1'b1) pv_seen++;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (bus.pos_valid === 1'b1) pv_seen++;
        end
        checks++; if (pv_seen != 1) begin errors++; $display("FAIL b2b_pv got %0d pulses want 1", pv_seen); end
        checks++; if (bus.red_circle_x !== 10'd322) begin errors++; $display("FAIL b2b_x got %0d want 322", bus.red_circle_x); end
    endtask

`ifdef MOTION_ACCEL_EN
    task automatic test_accel;
        int exp_x;
        int step;
        do_frame(5'b10000);
        exp_x = 320;
        for (int f = 1; f <= 70; f++) begin
            do_frame(5'b00001);
            step = 2 + (f - 1) / 16;
            if (step > 6) step = 6;
            exp_x += step;
            if (exp_x > 631) exp_x = 631;
            checks++; if (bus.red_circle_x !== 10'(exp_x)) begin errors++; $display("FAIL accel_x f%0d got %0d want %0d", f, bus.red_circle_x, exp_x); end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_move_right;
        test_clamp;
        test_opposite_center;
        test_reset_mid_calc;
        test_back_to_back_pulse;
`ifdef MOTION_ACCEL_EN
        test_accel;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
